// File: rtl/mem_side_pkg.sv
// ---------------------------------------------------------------------------
// mem_side_pkg : shared constants, FSM encoding and byte-lane helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_side_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int BE_W       = 4;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ST_ACCESS = 2'd1;
  localparam logic [1:0] S_LD_ACCESS = 2'd2;
  localparam logic [1:0] S_LD_NEXT   = 2'd3;

  function automatic logic [BE_W-1:0] byte_enable(input logic is_byte,
                                                  input logic [1:0] lane);
    logic [BE_W-1:0] one;
    one = BE_W'(1);
    byte_enable = is_byte ? (one << lane) : {BE_W{1'b1}};
  endfunction

  // Byte stores put the low byte on every lane; the enables pick the target.
  function automatic logic [31:0] lane_data(input logic is_byte,
                                            input logic [31:0] data);
    lane_data = is_byte ? {4{data[7:0]}} : data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_side_fill_ctr.sv
// ---------------------------------------------------------------------------
// mem_side_fill_ctr : critical-word-first offset and words-delivered counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_side_fill_ctr
  import mem_side_pkg::*;
(
  input  logic                sysclk,
  input  logic                nRESET,
  input  logic                load,
  input  logic [OFFSET_W-1:0] start,
  input  logic                advance,
  input  logic                clear,
  output logic [OFFSET_W-1:0] offset,
  output logic                last,
  output logic                done
);

  localparam logic [OFFSET_W:0] C_LAST = (OFFSET_W+1)'(LINE_WORDS-1);
  localparam logic [OFFSET_W:0] C_DONE = (OFFSET_W+1)'(LINE_WORDS);

  logic [OFFSET_W-1:0] r_offset;
  logic [OFFSET_W:0]   r_count;

  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      r_offset <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_offset <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_offset <= start;
      r_count  <= '0;
    end else if (advance) begin
      // natural overflow of the offset gives the 3 -> 0 wrap
      r_offset <= r_offset + OFFSET_W'(1);
      r_count  <= r_count + (OFFSET_W+1)'(1);
    end
  end

  assign offset = r_offset;
  assign last   = (r_count == C_LAST);
  assign done   = (r_count == C_DONE);

endmodule

`default_nettype wire

// File: rtl/mem_side_controller.sv
// ---------------------------------------------------------------------------
// mem_side_controller : write-buffer drains and 4-word line fills on req/ack bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_side_controller
  import mem_side_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                sysclk,
  input  logic                nRESET,
  input  logic                Load_Trigger,
  input  logic                Store_Trigger,
  input  logic [ADDR_W-1:0]   write_buffer_addr,
  input  logic [DATA_W-1:0]   write_buffer_data,
  input  logic                write_buffer_is_byte,
  output logic                st_busy,
  output logic                ld_busy,
  output logic                load_from_mem_req,
  output logic [DATA_W-1:0]   load_from_mem_data,
  output logic [OFFSET_W-1:0] load_from_mem_offset,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [BE_W-1:0]     mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                mem_err
);

  localparam int              TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]          r_state;
  logic                r_st_pending;
  logic [ADDR_W-1:0]   r_st_addr;
  logic [DATA_W-1:0]   r_st_data;
  logic                r_st_byte;
  logic                r_ld_pending;
  logic [ADDR_W-5:0]   r_line;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_err;
  logic                r_ld_req;
  logic [DATA_W-1:0]   r_ld_data;
  logic [OFFSET_W-1:0] r_ld_off;

  logic                w_in_access;
  logic                w_timeout;
  logic                w_st_cap;
  logic                w_ld_cap;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_last;
  logic                w_done;

  assign w_in_access = (r_state == S_ST_ACCESS) || (r_state == S_LD_ACCESS);
  assign w_timeout   = w_in_access && !mem_ack && (r_tmo == C_TMO_LAST);
  assign w_st_cap    = Store_Trigger && !r_st_pending;
  assign w_ld_cap    = Load_Trigger && !r_ld_pending;

  mem_side_fill_ctr u_fill_ctr (
    .sysclk  (sysclk),
    .nRESET  (nRESET),
    .load    (w_ld_cap),
    .start   (write_buffer_addr[3:2]),
    .advance ((r_state == S_LD_ACCESS) && mem_ack),
    .clear   ((r_state == S_LD_ACCESS) && w_timeout),
    .offset  (w_offset),
    .last    (w_last),
    .done    (w_done)
  );

  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      r_state      <= S_IDLE;
      r_st_pending <= 1'b0;
      r_st_addr    <= '0;
      r_st_data    <= '0;
      r_st_byte    <= 1'b0;
      r_ld_pending <= 1'b0;
      r_line       <= '0;
      r_err        <= 1'b0;
      r_ld_req     <= 1'b0;
      r_ld_data    <= '0;
      r_ld_off     <= '0;
    end else begin
      r_ld_req <= 1'b0;
      if (w_st_cap) begin
        r_st_pending <= 1'b1;
        r_st_addr    <= write_buffer_addr;
        r_st_data    <= write_buffer_data;
        r_st_byte    <= write_buffer_is_byte;
      end
      if (w_ld_cap) begin
        r_ld_pending <= 1'b1;
        r_line       <= write_buffer_addr[ADDR_W-1:4];
      end
      case (r_state)
        S_IDLE: begin
          // drain the write buffer first so a fill never returns stale data
          if (r_st_pending)      r_state <= S_ST_ACCESS;
          else if (r_ld_pending) r_state <= S_LD_ACCESS;
        end
        S_ST_ACCESS: begin
          if (mem_ack || w_timeout) begin
            r_st_pending <= 1'b0;
            r_state      <= S_IDLE;
            if (!mem_ack) r_err <= 1'b1;
          end
        end
        S_LD_ACCESS: begin
          if (mem_ack) begin
            r_ld_req  <= 1'b1;
            r_ld_data <= mem_rdata;
            r_ld_off  <= w_offset;
            if (w_last) r_ld_pending <= 1'b0;
            r_state   <= S_LD_NEXT;
          end else if (w_timeout) begin
            r_err        <= 1'b1;
            r_ld_pending <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= w_done ? S_IDLE : S_LD_ACCESS;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET)                                 r_tmo <= '0;
    else if (!w_in_access || mem_ack || w_timeout) r_tmo <= '0;
    else                                         r_tmo <= r_tmo + TMO_W'(1);
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (r_state)
      S_ST_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_st_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = lane_data(r_st_byte, r_st_data);
        mem_be    = byte_enable(r_st_byte, r_st_addr[1:0]);
      end
      S_LD_ACCESS: begin
        mem_req  = 1'b1;
        mem_be   = {BE_W{1'b1}};
        mem_addr = {r_line, w_offset, 2'b00};
      end
      default: ;
    endcase
  end

  assign st_busy              = r_st_pending;
  assign ld_busy              = r_ld_pending;
  assign load_from_mem_req    = r_ld_req;
  assign load_from_mem_data   = r_ld_data;
  assign load_from_mem_offset = r_ld_off;
  assign mem_err              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_side_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_side_controller : directed stimulus with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_side_controller;

  logic        sysclk = 1'b0;
  logic        nRESET = 1'b0;
  logic        Load_Trigger = 1'b0;
  logic        Store_Trigger = 1'b0;
  logic [31:0] write_buffer_addr = '0;
  logic [31:0] write_buffer_data = '0;
  logic        write_buffer_is_byte = 1'b0;
  logic        st_busy, ld_busy, load_from_mem_req;
  logic [31:0] load_from_mem_data;
  logic [1:0]  load_from_mem_offset;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err;

  mem_side_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .sysclk               (sysclk),
    .nRESET               (nRESET),
    .Load_Trigger         (Load_Trigger),
    .Store_Trigger        (Store_Trigger),
    .write_buffer_addr    (write_buffer_addr),
    .write_buffer_data    (write_buffer_data),
    .write_buffer_is_byte (write_buffer_is_byte),
    .st_busy              (st_busy),
    .ld_busy              (ld_busy),
    .load_from_mem_req    (load_from_mem_req),
    .load_from_mem_data   (load_from_mem_data),
    .load_from_mem_offset (load_from_mem_offset),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .mem_err              (mem_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  off;
    logic        last;
  } fill_t;

  acc_t  exp_acc[$];
  fill_t exp_fill[$];
  int    checks = 0;
  int    errors = 0;
  int    fills_seen = 0;
  logic  ack_en = 1'b1;
  logic  spur = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the four accesses and returned words a fill must produce.
  task automatic expect_fill(input logic [31:0] addr);
    int off;
    logic [31:0] w;
    off = int'((addr >> 2) & 32'd3);
    for (int i = 0; i < 4; i++) begin
      w = (addr & 32'hFFFF_FFF0) + 32'(((off + i) % 4) * 4);
      exp_acc.push_back('{addr: w, we: 1'b0, be: 4'hF, wdata: 32'h0});
      exp_fill.push_back('{data: w, off: 2'((off + i) % 4), last: (i == 3)});
    end
  endtask

  task automatic expect_store(input logic [31:0] addr, input logic [31:0] data, input logic is_byte);
    acc_t a;
    a.addr  = addr & 32'hFFFF_FFFC;
    a.we    = 1'b1;
    a.be    = is_byte ? 4'(1 << (addr & 32'd3)) : 4'hF;
    a.wdata = is_byte ? (data & 32'hFF) * 32'h0101_0101 : data;
    exp_acc.push_back(a);
  endtask

  task automatic trig(input logic ld, input logic st, input logic [31:0] addr,
                      input logic [31:0] data, input logic isb);
    @(negedge sysclk);
    Load_Trigger = ld; Store_Trigger = st;
    write_buffer_addr = addr; write_buffer_data = data; write_buffer_is_byte = isb;
    @(posedge sysclk); #1;
    Load_Trigger = 1'b0; Store_Trigger = 1'b0;
  endtask

  task automatic step();
    @(posedge sysclk); #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((st_busy || ld_busy || exp_acc.size() != 0 || exp_fill.size() != 0) && n < max) begin
      @(posedge sysclk); #2;
      n++;
    end
    check({name, "_done_in_budget"}, n < max, 1'b1);
  endtask

  // Memory responder: acks on the 2nd cycle of a request, data = address.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge sysclk);
      if (mem_ack) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (spur) begin
        mem_ack = 1'b1; spur = 1'b0;
      end else if (mem_req && ack_en && nRESET) begin
        cnt++;
        if (cnt >= 2) begin mem_ack = 1'b1; mem_rdata = mem_addr; end
      end else begin
        cnt = 0;
      end
    end
  end

  // Compare process: every access start and every fill word against the model.
  initial begin
    logic  prev_req;
    acc_t  a;
    fill_t f;
    prev_req = 1'b0;
    forever begin
      @(posedge sysclk); #1;
      if (!nRESET) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          check("access_expected", exp_acc.size() > 0, 1'b1);
          if (exp_acc.size() > 0) begin
            a = exp_acc.pop_front();
            check("acc_addr", mem_addr, a.addr);
            check("acc_we", mem_we, a.we);
            check("acc_be", mem_be, a.be);
            if (a.we) check("acc_wdata", mem_wdata, a.wdata);
          end
        end
        if (mem_req) check("addr_align", mem_addr[1:0], 2'b00);
        if (load_from_mem_req) begin
          fills_seen++;
          check("fill_expected", exp_fill.size() > 0, 1'b1);
          if (exp_fill.size() > 0) begin
            f = exp_fill.pop_front();
            check("fill_data", load_from_mem_data, f.data);
            check("fill_offset", load_from_mem_offset, f.off);
            check("fill_ld_busy", ld_busy, !f.last);
          end
        end
        prev_req = mem_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge sysclk);
    #1;
    check("rst_busy_req", {st_busy, ld_busy, load_from_mem_req, mem_req, mem_we, mem_err}, 6'b0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    check("rst_fill_be", {load_from_mem_data, load_from_mem_offset, mem_be}, 38'h0);
    @(negedge sysclk); nRESET = 1'b1;

    // fill from offset 0
    expect_fill(32'h0000_0001);
    trig(1'b1, 1'b0, 32'h0000_0001, 32'h0, 1'b0);
    check("fill0_ld_busy_next", ld_busy, 1'b1);
    wait_idle("fill0", 60);

    // critical-word-first wrap
    expect_fill(32'h0000_040C);
    trig(1'b1, 1'b0, 32'h0000_040C, 32'h0, 1'b0);
    step();
    check("wrap_first_addr", mem_addr, 32'h0000_040C);
    wait_idle("wrap", 60);

    // byte store
    expect_store(32'h2, 32'hABCD_9876, 1'b1);
    trig(1'b0, 1'b1, 32'h2, 32'hABCD_9876, 1'b1);
    check("bst_st_busy_next", st_busy, 1'b1);
    step();
    check("bst_be", mem_be, 4'b0100);
    check("bst_wdata", mem_wdata, 32'h7676_7676);
    step();
    check("bst_busy_during", st_busy, 1'b1);
    step();
    check("bst_busy_after_ack", st_busy, 1'b0);
    wait_idle("bst", 20);

    // simultaneous triggers: store drains before the fill
    expect_store(32'h10, 32'h1122_3344, 1'b0);
    expect_fill(32'h10);
    trig(1'b1, 1'b1, 32'h10, 32'h1122_3344, 1'b0);
    step();
    check("sim_store_first_we", mem_we, 1'b1);
    check("sim_ld_busy_held", ld_busy, 1'b1);
    wait_idle("sim", 80);

    // stray ack with nothing in flight
    @(negedge sysclk); spur = 1'b1;
    repeat (4) step();
    check("spur_idle", {st_busy, ld_busy, mem_req, mem_err}, 4'b0);

    // timeout: 8 request cycles, then abort
    ack_en = 1'b0;
    exp_acc.push_back('{addr: 32'h20, we: 1'b0, be: 4'hF, wdata: 32'h0});
    trig(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    repeat (8) step();
    check("tmo_req_last_cycle", {mem_req, mem_err}, 2'b10);
    step();
    check("tmo_err_set", {mem_err, mem_req, ld_busy}, 3'b100);
    ack_en = 1'b1;
    expect_fill(32'h34);
    trig(1'b1, 1'b0, 32'h34, 32'h0, 1'b0);
    wait_idle("post_tmo", 60);
    check("tmo_err_sticky", mem_err, 1'b1);

    // reset after the 2nd fill word
    expect_fill(32'h50);
    trig(1'b1, 1'b0, 32'h50, 32'h0, 1'b0);
    begin
      int n;
      n = 0;
      while (fills_seen % 4 != 2 && n < 40) begin @(posedge sysclk); #2; n++; end
      check("rst_mid_reached", n < 40, 1'b1);
    end
    nRESET = 1'b0;
    #1;
    check("rstm_busy_req", {st_busy, ld_busy, load_from_mem_req, mem_req, mem_we, mem_err}, 6'b0);
    check("rstm_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    check("rstm_fill_be", {load_from_mem_data, load_from_mem_offset, mem_be}, 38'h0);
    exp_acc.delete();
    exp_fill.delete();
    repeat (2) @(posedge sysclk);
    @(negedge sysclk); nRESET = 1'b1;
    begin
      int seen0;
      seen0 = fills_seen;
      repeat (20) step();
      check("rstm_no_more_fill", fills_seen - seen0, 0);
    end
    check("rstm_idle", {ld_busy, mem_req}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
